btb_update_unit: RTL

Write-side companion of the fetch-stage branch predictor. It accepts resolved control-flow instructions from the branch-resolve stage and detects mispredictions, producing a flush and the corrected PC. It drives the predictor's global 2-bit counter update and queues Branch Target Buffer (BTB) writes behind a handshake to the BTB array. After reset it sweeps the whole BTB to the invalid pattern before it accepts any resolve traffic.

---
 rtl/bp_pkg.sv | 43 ++++
 rtl/btb_write_fifo.sv | 62 ++++++
 rtl/btb_update_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: widths, BTB encodings and resolve-stage opcodes.
package bp_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned IDX_W       = 8;
    localparam int unsigned TAG_W       = 8;
    localparam int unsigned QDEPTH      = 4;
    localparam int unsigned BTB_ENTRIES = 1 << IDX_W;
    localparam int unsigned QPTR_W      = $clog2(QDEPTH);
    localparam int unsigned QCNT_W      = $clog2(QDEPTH + 1);
    localparam int unsigned OPC_W       = 4;

    localparam logic [WORD_SIZE-1:0] BTB_INVALID_TARGET = 16'hFFFF;
    localparam logic [TAG_W-1:0]     BTB_INVALID_TAG    = 8'h00;

    // Control-flow opcodes as decoded by the resolve stage
    localparam logic [OPC_W-1:0] OP_BNE = 4'h0;
    localparam logic [OPC_W-1:0] OP_BEQ = 4'h1;
    localparam logic [OPC_W-1:0] OP_BGZ = 4'h2;
    localparam logic [OPC_W-1:0] OP_BLZ = 4'h3;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h9;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [WORD_SIZE-1:0] target;
    } btb_entry_t;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        btb_entry_t       entry;
    } btb_wr_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } upd_state_e;

    // Sequential next PC; wraps modulo 2^WORD_SIZE
    function automatic logic [WORD_SIZE-1:0] fallthrough_pc(input logic [WORD_SIZE-1:0] pc);
        return WORD_SIZE'(pc + WORD_SIZE'(1));
    endfunction

endpackage

// File: rtl/btb_write_fifo.sv
// Show-ahead write queue for BTB updates with in-place tail overwrite.
// head_nxt/count_nxt give the values that will be current after the next edge,
// so the consumer can register its outputs without adding latency.
module btb_write_fifo
    import bp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              overwrite,
    input  logic              pop,
    input  btb_wr_t           wr_data,
    output btb_wr_t           head_nxt,
    output logic [IDX_W-1:0]  tail_index,
    output logic [QCNT_W-1:0] count,
    output logic [QCNT_W-1:0] count_nxt
);

    btb_wr_t           mem [QDEPTH];
    logic [QPTR_W-1:0] rd_ptr;
    logic [QPTR_W-1:0] wr_ptr;
    logic [QPTR_W-1:0] tail_ptr;
    logic [QPTR_W-1:0] rd_ptr_nxt;

    assign tail_ptr   = QPTR_W'(wr_ptr - QPTR_W'(1));
    assign tail_index = mem[tail_ptr].index;
    assign rd_ptr_nxt = QPTR_W'(rd_ptr + QPTR_W'(pop));
    assign count_nxt  = QCNT_W'(count + QCNT_W'(push) - QCNT_W'(pop));

    // Look-ahead head: forward write data when it lands in the next head slot
    always_comb begin
        head_nxt = mem[rd_ptr_nxt];
        if ((push && (wr_ptr == rd_ptr_nxt)) || (overwrite && (tail_ptr == rd_ptr_nxt))) begin
            head_nxt = wr_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (push) begin
                wr_ptr <= QPTR_W'(wr_ptr + QPTR_W'(1));
            end
            count <= count_nxt;
        end
    end

    // Storage array; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end else if (overwrite) begin
            mem[tail_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/btb_update_unit.sv
// Branch-resolve write side: misprediction flush, counter update strobe and
// queued BTB writes, preceded by a full BTB invalidation sweep after reset.
module btb_update_unit
    import bp_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       res_valid,
    input  logic                       res_is_branch,
    input  logic [WORD_SIZE-1:0]       res_PC,
    input  logic                       res_taken,
    input  logic [WORD_SIZE-1:0]       res_target,
    input  logic [WORD_SIZE-1:0]       res_pred_PC,
    output logic                       res_ready,
    output logic                       flush,
    output logic [WORD_SIZE-1:0]       correct_PC,
    output logic                       ctr_update,
    output logic                       ctr_taken,
    output logic                       btb_we,
    input  logic                       btb_wready,
    output logic [IDX_W-1:0]           btb_index,
    output logic [TAG_W+WORD_SIZE-1:0] btb_wdata,
    output logic                       init_done
);

    upd_state_e                 state;
    upd_state_e                 state_nxt;
    logic [IDX_W-1:0]           sweep_idx;
    logic [IDX_W-1:0]           sweep_idx_nxt;

    logic                       sweep_fire;
    logic                       accept;
    logic                       wr_req;
    logic                       coalesce;
    logic                       fifo_push;
    logic                       fifo_ovw;
    logic                       fifo_pop;
    logic [WORD_SIZE-1:0]       actual_pc;
    btb_wr_t                    push_data;
    btb_wr_t                    head_nxt;
    logic [IDX_W-1:0]           tail_index;
    logic [QCNT_W-1:0]          count;
    logic [QCNT_W-1:0]          count_nxt;

    logic                       res_ready_d;
    logic                       flush_d;
    logic [WORD_SIZE-1:0]       correct_pc_d;
    logic                       ctr_update_d;
    logic                       ctr_taken_d;
    logic                       btb_we_d;
    logic [IDX_W-1:0]           btb_index_d;
    logic [TAG_W+WORD_SIZE-1:0] btb_wdata_d;
    logic                       init_done_d;

    // Resolve decode: acceptance, actual next PC and queue controls
    always_comb begin
        sweep_fire       = (state == ST_INIT) && btb_we && btb_wready;
        fifo_pop         = (state == ST_RUN) && btb_we && btb_wready;
        accept           = res_valid && res_ready;
        actual_pc        = res_taken ? res_target : fallthrough_pc(res_PC);
        wr_req           = accept && res_taken;
        // Merging only with a tail that is not also the presented head
        coalesce         = (count >= QCNT_W'(2)) && (tail_index == res_PC[IDX_W-1:0]);
        fifo_push        = wr_req && !coalesce;
        fifo_ovw         = wr_req && coalesce;
        push_data        = '0;
        push_data.index  = res_PC[IDX_W-1:0];
        push_data.entry.tag    = res_PC[WORD_SIZE-1 -: TAG_W];
        push_data.entry.target = res_target;
    end

    btb_write_fifo u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .overwrite  (fifo_ovw),
        .pop        (fifo_pop),
        .wr_data    (push_data),
        .head_nxt   (head_nxt),
        .tail_index (tail_index),
        .count      (count),
        .count_nxt  (count_nxt)
    );

    // FSM state and sweep index register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // Next state: leave INIT once the last BTB index has been written
    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        if (sweep_fire) begin
            sweep_idx_nxt = IDX_W'(sweep_idx + IDX_W'(1));
            if (sweep_idx == IDX_W'(BTB_ENTRIES - 1)) begin
                state_nxt = ST_RUN;
            end
        end
    end

    // Output next values, derived from the post-edge state and queue
    always_comb begin
        flush_d      = accept && (actual_pc != res_pred_PC);
        correct_pc_d = accept ? actual_pc : '0;
        ctr_update_d = accept && res_is_branch;
        ctr_taken_d  = accept && res_is_branch && res_taken;
        btb_we_d     = 1'b0;
        btb_index_d  = '0;
        btb_wdata_d  = '0;
        res_ready_d  = 1'b0;
        init_done_d  = 1'b0;
        if (state_nxt == ST_INIT) begin
            btb_we_d    = 1'b1;
            btb_index_d = sweep_idx_nxt;
            btb_wdata_d = {BTB_INVALID_TAG, BTB_INVALID_TARGET};
        end else begin
            init_done_d = 1'b1;
            res_ready_d = (count_nxt < QCNT_W'(QDEPTH));
            if (count_nxt != '0) begin
                btb_we_d    = 1'b1;
                btb_index_d = head_nxt.index;
                btb_wdata_d = head_nxt.entry;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_ready  <= 1'b0;
            flush      <= 1'b0;
            correct_PC <= '0;
            ctr_update <= 1'b0;
            ctr_taken  <= 1'b0;
            btb_we     <= 1'b0;
            btb_index  <= '0;
            btb_wdata  <= '0;
            init_done  <= 1'b0;
        end else begin
            res_ready  <= res_ready_d;
            flush      <= flush_d;
            correct_PC <= correct_pc_d;
            ctr_update <= ctr_update_d;
            ctr_taken  <= ctr_taken_d;
            btb_we     <= btb_we_d;
            btb_index  <= btb_index_d;
            btb_wdata  <= btb_wdata_d;
            init_done  <= init_done_d;
        end
    end

endmodule
